// File: rtl/change_dispenser.sv
// Greedy coin payout: ejects ten-unit then one-unit coin pulses until the latched amount is paid.
// Optional hopper acknowledge with timeout fault is enabled by defining DISPENSE_ACK_EN.
module change_dispenser #(
  parameter int VAL_W       = 10,
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] amount,
  input  logic             ten_empty,
`ifdef DISPENSE_ACK_EN
  input  logic             coin_ack,
  output logic             fault,
`endif
  output logic             coin_ten_out,
  output logic             coin_one_out,
  output logic             busy,
  output logic             done,
  output logic [VAL_W-1:0] remain
);

  localparam int MAX_PG  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_MAX = (MAX_PG > ACK_TIMEOUT) ? MAX_PG : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
  localparam logic [VAL_W-1:0] TEN_VAL    = VAL_W'(10);
  localparam logic [VAL_W-1:0] ONE_VAL    = VAL_W'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
`ifdef DISPENSE_ACK_EN
  localparam logic [2:0] S_WAIT_ACK = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [VAL_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             selTen_q, selTen_d;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    selTen_d = selTen_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = amount;
          selTen_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        // ten_empty only matters here, so a hopper change mid-coin waits for the next coin
        if (remain_q >= TEN_VAL && !ten_empty) begin
          selTen_d = 1'b1;
          state_d  = S_PULSE;
        end else if (remain_q != '0) begin
          selTen_d = 1'b0;
          state_d  = S_PULSE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d    = '0;
          remain_d = remain_q - (selTen_q ? TEN_VAL : ONE_VAL);
          state_d  = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
`ifdef DISPENSE_ACK_EN
          state_d = S_WAIT_ACK;
`else
          state_d = S_SELECT;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DISPENSE_ACK_EN
      S_WAIT_ACK: begin
        if (coin_ack) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else if (cnt_q == ACK_LAST) begin
          cnt_d   = '0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      cnt_q    <= '0;
      selTen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      selTen_q <= selTen_d;
    end
  end

  // Outputs decode straight from registered state so an async reset drops them at once
  assign coin_ten_out = (state_q == S_PULSE) &&  selTen_q;
  assign coin_one_out = (state_q == S_PULSE) && !selTen_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign remain       = remain_q;
`ifdef DISPENSE_ACK_EN
  assign fault        = (state_q == S_FAULT);
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table plus scoreboard of expected coin pulses.
// The DISPENSE_ACK_EN sections exercise the hopper acknowledge/timeout build.
module tb_change_dispenser;
  localparam int VAL_W   = 10;
  localparam int PULSE_W = 4;
  localparam int GAP_W   = 4;
`ifdef DISPENSE_ACK_EN
  localparam int ACK_TIMEOUT = 64;
  localparam int COIN_CYC    = 1 + PULSE_W + GAP_W + 1;
`else
  localparam int COIN_CYC    = 1 + PULSE_W + GAP_W;
`endif
  localparam int MAX_EDGES = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [VAL_W-1:0] amount;
  logic             ten_empty;
  logic             coin_ten_out, coin_one_out, busy, done;
  logic [VAL_W-1:0] remain;
`ifdef DISPENSE_ACK_EN
  logic             coin_ack;
  logic             fault;
`endif

  typedef struct {
    int amt;
    bit te;
    int tens;
    int ones;
  } vec_t;

  vec_t vecs[8];
  int   expQ[$];
  int   remHist[MAX_EDGES+1];
  int   errors = 0;
  int   checks = 0;
  int   doneCount = 0;
  int   highCnt = 0;
  bit   prevTen = 1'b0, prevOne = 1'b0;

  change_dispenser #(.VAL_W(VAL_W), .PULSE_W(PULSE_W), .GAP_W(GAP_W)
`ifdef DISPENSE_ACK_EN
                     , .ACK_TIMEOUT(ACK_TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .ten_empty(ten_empty),
`ifdef DISPENSE_ACK_EN
    .coin_ack(coin_ack), .fault(fault),
`endif
    .coin_ten_out(coin_ten_out), .coin_one_out(coin_one_out),
    .busy(busy), .done(done), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic popCoin(input int val);
    if (expQ.size() == 0) checkOutput("unexpected_coin", val, 0);
    else checkOutput("coin_value", val, expQ.pop_front());
  endtask

  // Monitor on the falling edge: pops the scoreboard on each pulse start, measures pulse width
  always @(negedge clk) begin
    if (!reset) begin
      prevTen = 1'b0;
      prevOne = 1'b0;
      highCnt = 0;
    end else begin
      if (coin_ten_out && coin_one_out) checkOutput("both_outputs_high", 1, 0);
      if (coin_ten_out && !prevTen) popCoin(10);
      if (coin_one_out && !prevOne) popCoin(1);
      if (coin_ten_out || coin_one_out) highCnt++;
      else if (prevTen || prevOne) begin
        checkOutput("pulse_width", highCnt, PULSE_W);
        highCnt = 0;
      end
      if (done) doneCount++;
      prevTen = coin_ten_out;
      prevOne = coin_one_out;
    end
  end

  // Runs one payout from IDLE; optional second start mid-payout and start during the DONE cycle
  task automatic applyStimulus(input int a, input bit te, input int tens, input int ones,
                               input int extraAt, input bit startInDone, output int latency);
    int n;
    @(negedge clk);
    for (int k = 0; k < tens; k++) expQ.push_back(10);
    for (int k = 0; k < ones; k++) expQ.push_back(1);
    amount    = VAL_W'(a);
    ten_empty = te;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
    n = 0;
    latency = -1;
    remHist[0] = remain;
    while (n < MAX_EDGES) begin
      @(posedge clk); #1;
      n++;
      remHist[n] = remain;
      if (n == extraAt) begin
        start  = 1'b1;
        amount = VAL_W'(5);
      end
      if (n == extraAt + 2) start = 1'b0;
      if (done) begin
        latency = n;
        break;
      end
    end
    if (latency < 0) checkOutput("done_timeout", 0, 1);
    checkOutput("remain_at_done", remain, 0);
    checkOutput("busy_at_done", busy, 0);
    if (startInDone) begin
      start  = 1'b1;
      amount = VAL_W'(7);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("done_one_cycle", done, 0);
    if (startInDone) checkOutput("start_in_done_ignored", busy, 0);
    checkOutput("coins_left", expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, dc;
    vecs[0] = '{13,   1'b0, 1,   3};
    vecs[1] = '{12,   1'b1, 0,   12};
    vecs[2] = '{0,    1'b0, 0,   0};
    vecs[3] = '{9,    1'b0, 0,   9};
    vecs[4] = '{10,   1'b0, 1,   0};
    vecs[5] = '{19,   1'b0, 1,   9};
    vecs[6] = '{30,   1'b1, 0,   30};
    vecs[7] = '{1023, 1'b0, 102, 3};

    reset = 1'b0; start = 1'b0; amount = '0; ten_empty = 1'b0;
`ifdef DISPENSE_ACK_EN
    coin_ack = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ten", coin_ten_out, 0);
    checkOutput("reset_one", coin_one_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_remain", remain, 0);
`ifdef DISPENSE_ACK_EN
    checkOutput("reset_fault", fault, 0);
`endif
    @(posedge clk); #2;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].amt, vecs[i].te, vecs[i].tens, vecs[i].ones, -1, 1'b0, lat);
      checkOutput($sformatf("latency_amt%0d", vecs[i].amt), lat,
                  (vecs[i].tens + vecs[i].ones) * COIN_CYC + 1);
    end

    // remain trace for 13: drops on the last pulse cycle of each coin
    applyStimulus(13, 1'b0, 1, 3, -1, 1'b0, lat);
    checkOutput("remain_before_first_dec", remHist[4], 13);
    checkOutput("remain_after_ten", remHist[5], 3);
    checkOutput("remain_after_one_a", remHist[5 + COIN_CYC], 2);
    checkOutput("remain_after_one_b", remHist[5 + 2*COIN_CYC], 1);
    checkOutput("remain_after_one_c", remHist[5 + 3*COIN_CYC], 0);

    // Reset during the second ten pulse of 25
    @(negedge clk);
    expQ.push_back(10); expQ.push_back(10);
    amount = VAL_W'(25); ten_empty = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (COIN_CYC + 2) @(posedge clk);
    #1;
    checkOutput("mid_second_ten_high", coin_ten_out, 1);
    checkOutput("remain_mid_second_ten", remain, 15);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_ten", coin_ten_out, 0);
    checkOutput("async_reset_one", coin_one_out, 0);
    checkOutput("async_reset_remain", remain, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("coins_before_reset", expQ.size(), 0);
    expQ.delete();
    @(posedge clk); #2;
    reset = 1'b1;
    applyStimulus(1, 1'b0, 0, 1, -1, 1'b0, lat);
    checkOutput("latency_after_reset", lat, COIN_CYC + 1);

    // Start while busy and start in DONE are both ignored
    dc = doneCount;
    applyStimulus(20, 1'b0, 2, 0, 3, 1'b1, lat);
    checkOutput("latency_double_start", lat, 2*COIN_CYC + 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count_double_start", doneCount - dc, 1);
    checkOutput("idle_after_double_start", busy, 0);

`ifdef DISPENSE_ACK_EN
    // Ack only for the first coin: second coin's ack wait times out into FAULT
    begin
      int n;
      @(negedge clk);
      expQ.push_back(10); expQ.push_back(1);
      amount = VAL_W'(11); ten_empty = 1'b0; coin_ack = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (n = 1; n <= 2*COIN_CYC - 1 + ACK_TIMEOUT; n++) begin
        @(posedge clk); #1;
        if (n == COIN_CYC) coin_ack = 1'b0;
        if (n == 2*COIN_CYC - 2 + ACK_TIMEOUT) checkOutput("fault_before_timeout", fault, 0);
      end
      checkOutput("fault_at_timeout", fault, 1);
      checkOutput("fault_busy", busy, 1);
      checkOutput("fault_remain", remain, 0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("fault_sticky", fault, 1);
      checkOutput("fault_outputs_low", coin_ten_out | coin_one_out, 0);
      checkOutput("fault_coins_left", expQ.size(), 0);
      reset = 1'b0;
      #1;
      checkOutput("fault_cleared_by_reset", fault, 0);
      @(posedge clk); #2;
      reset = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
